// File: rtl/debounce_scheduler.sv
// Shared debounce evaluator: a prescaled tick launches a scan that visits one input per clock.
// Define DEBOUNCE_EDGE_EN to build the registered rise/fall pulse outputs; otherwise they read 0.
module debounce_scheduler #(
    parameter int N_INPUTS = 3,
    parameter int HISTORY  = 8,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_INPUTS-1:0] buttons,
    output logic [N_INPUTS-1:0] debounced,
    output logic [N_INPUTS-1:0] rise,
    output logic [N_INPUTS-1:0] fall,
    output logic                busy
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state, state_next;
    logic [IW-1:0]         idx, idx_next;
    logic [CW-1:0]         cnt;
    logic                  tick;
    logic [HISTORY-1:0]    history [N_INPUTS];
    logic [HISTORY-1:0]    h_next;
    logic                  all_ones, all_zeros;

    assign tick = enable && (cnt == CW'(PRESCALE - 1));

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latches).
    always_comb begin
        state_next = state;
        idx_next   = idx;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (idx == IW'(N_INPUTS - 1)) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // The level decision looks at the history including the sample taken this clock.
    assign h_next    = {history[idx][HISTORY-2:0], buttons[idx]};
    assign all_ones  = &h_next;
    assign all_zeros = ~|h_next;

    // NOTE: the history array is small register storage that must start from all-zeros, so it is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                history[i] <= '0;
            end
            debounced <= '0;
        end else if (state == SCAN) begin
            history[idx] <= h_next;
            if (all_ones) begin
                debounced[idx] <= 1'b1;
            end else if (all_zeros) begin
                debounced[idx] <= 1'b0;
            end
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= '0;
            fall <= '0;
            if (state == SCAN) begin
                rise[idx] <= all_ones && !debounced[idx];
                fall[idx] <= all_zeros && debounced[idx];
            end
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule
